// File: rtl/rs232_pkg.sv
// rs232_pkg: state encoding, parity modes and default baud divisor shared by the RS232 blocks
package rs232_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_POP_REQ, S_POP_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD = 1;
   localparam int PARITY_EVEN = 2;
   localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/rs232_bit_timer.sv
// rs232_bit_timer: baud divider that pulses bit_tick on the last cycle of every bit period
module rs232_bit_timer import rs232_pkg::*; #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic clear_n,
   input  logic run,
   output logic bit_tick
);
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   logic [15:0] cnt_q, cnt_d;
   assign bit_tick = run && cnt_q == LAST;
   // held at zero while stopped, so every rising run starts a full bit period
   assign cnt_d = (!run || bit_tick) ? '0 : cnt_q + 16'd1;
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
endmodule

// File: rtl/rs232_fifo_transmitter.sv
// rs232_fifo_transmitter: pops one FIFO word at a time and serialises it as an RS232 frame
module rs232_fifo_transmitter import rs232_pkg::*; #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS = 8,
   parameter int FIFO_WIDTH = 32,
   parameter int PARITY = PARITY_NONE,
   parameter int STOP_BITS = 1,
   parameter int POP_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  clear_n,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [FIFO_WIDTH-1:0] fifo_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic [2:0] LAST_WAIT = 3'(POP_LATENCY - 1);
   localparam logic ODD = 1'(PARITY == PARITY_ODD);
   state_e state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [2:0] wait_q, wait_d;
   logic par_q, par_d, tx_q, tx_d, run, tick, unused_hi;
   assign run = state_q inside {S_START, S_DATA, S_PARITY, S_STOP};
   assign fifo_pop = state_q == S_POP_REQ;
   assign busy = state_q != S_IDLE;
   assign frame_done = state_q == S_STOP && tick && bit_q == LAST_STOP;
   assign tx = tx_q;
   assign unused_hi = ^fifo_data;
   rs232_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk(clk),
      .clear_n(clear_n),
      .run(run),
      .bit_tick(tick)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d = bit_q;
      wait_d = wait_q;
      par_d = par_q;
      case (state_q)
         S_IDLE: state_d = (enable && !fifo_empty) ? S_POP_REQ : S_IDLE;
         S_POP_REQ: begin
            state_d = S_POP_WAIT;
            wait_d = '0;
         end
         S_POP_WAIT: begin
            wait_d = wait_q + 3'd1;
            if (wait_q == LAST_WAIT) begin
               shift_d = fifo_data[DATA_BITS-1:0];
               par_d = ODD ^ (^fifo_data[DATA_BITS-1:0]);
               state_d = S_START;
            end
         end
         S_START: begin
            bit_d = '0;
            if (tick) state_d = S_DATA;
         end
         S_DATA: if (tick) begin
            shift_d = shift_q >> 1;
            bit_d = bit_q == LAST_DATA ? '0 : bit_q + 1'b1;
            state_d = bit_q != LAST_DATA ? S_DATA : PARITY != PARITY_NONE ? S_PARITY : S_STOP;
         end
         S_PARITY: if (tick) state_d = S_STOP;
         S_STOP: if (tick) begin
            bit_d = bit_q + 1'b1;
            if (bit_q == LAST_STOP) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // tx is registered from the next state so the line carries no input-to-output path
      tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] :
             state_d == S_PARITY ? par_d : 1'b1;
   end
   always_ff @(posedge clk or negedge clear_n)
      if (!clear_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         bit_q <= '0;
         wait_q <= '0;
         par_q <= 1'b0;
         tx_q <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q <= bit_d;
         wait_q <= wait_d;
         par_q <= par_d;
         tx_q <= tx_d;
      end
endmodule

// File: tb/tb_rs232_fifo_transmitter.sv
// tb_rs232_fifo_transmitter: directed checks of three transmitter configurations fed by FIFO models
module tb_rs232_fifo_transmitter;
   localparam int PL = 2;
   logic clk = 1'b0;
   logic clear_n = 1'b1;
   logic en [3];
   logic empty [3];
   logic pop [3];
   logic tx [3];
   logic busy [3];
   logic done [3];
   logic [31:0] data [3];
   logic [31:0] hold [3];
   logic [31:0] mem [3][16];
   int rd [3] = '{0, 0, 0};
   int wr [3] = '{0, 0, 0};
   int npop [3] = '{0, 0, 0};
   int cd [3] = '{0, 0, 0};
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // instance 0: no parity, 1 stop; 1: even parity, 2 stops; 2: odd parity, 1 stop
   for (genvar g = 0; g < 3; g++) begin : g_dut
      rs232_fifo_transmitter #(
         .CLKS_PER_BIT(4), .DATA_BITS(8), .FIFO_WIDTH(32),
         .PARITY(g == 0 ? 0 : g == 1 ? 2 : 1), .STOP_BITS(g == 1 ? 2 : 1), .POP_LATENCY(PL)
      ) u_dut (
         .clk(clk), .clear_n(clear_n), .enable(en[g]), .fifo_empty(empty[g]),
         .fifo_pop(pop[g]), .fifo_data(data[g]), .tx(tx[g]), .busy(busy[g]),
         .frame_done(done[g])
      );
   end

   always_comb for (int i = 0; i < 3; i++) empty[i] = rd[i] == wr[i];

   // FIFO model: data shows the inverted word until POP_LATENCY cycles after the pop
   always @(posedge clk)
      for (int i = 0; i < 3; i++)
         if (pop[i]) begin
            hold[i] <= mem[i][rd[i]];
            data[i] <= ~mem[i][rd[i]];
            rd[i] <= rd[i] + 1;
            npop[i] <= npop[i] + 1;
            cd[i] <= PL - 1;
         end else if (cd[i] == 1) begin
            cd[i] <= 0;
            data[i] <= hold[i];
         end else if (cd[i] > 1) cd[i] <= cd[i] - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] w);
      mem[i][wr[i]] = w;
      wr[i]++;
   endtask

   // waits for the start bit, then checks every cycle of the frame and the done pulse
   task automatic frame(input int i, input logic [7:0] d, input int par, input int stops,
                        input int drop, output int gap);
      logic [11:0] seq;
      int n;
      seq = '0;
      for (int b = 0; b < 8; b++) seq[b + 1] = d[b];
      n = 9;
      if (par != 0) begin
         seq[n] = par == 2 ? ^d : ~^d;
         n++;
      end
      for (int s = 0; s < stops; s++) begin
         seq[n] = 1'b1;
         n++;
      end
      gap = 0;
      while (tx[i] !== 1'b0 && gap < 200) begin
         @(negedge clk);
         gap++;
      end
      chk($sformatf("start_seen u%0d d%0h", i, d), 32'(tx[i]), 0);
      chk($sformatf("busy_in_frame u%0d", i), 32'(busy[i]), 1);
      for (int c = 0; c < n * 4; c++) begin
         if (c == drop) en[i] = 1'b0;
         chk($sformatf("tx u%0d d%0h c%0d", i, d, c), 32'(tx[i]), 32'(seq[c / 4]));
         if (c >= n * 4 - 2)
            chk($sformatf("frame_done u%0d c%0d", i, c), 32'(done[i]), 32'(c == n * 4 - 1));
         @(negedge clk);
      end
      chk($sformatf("busy_after u%0d", i), 32'(busy[i]), 0);
   endtask

   initial begin
      int gap;
      en = '{1'b0, 1'b0, 1'b0};
      #2 clear_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_tx u%0d", i), 32'(tx[i]), 1);
         chk($sformatf("rst_busy u%0d", i), 32'(busy[i]), 0);
         chk($sformatf("rst_pop u%0d", i), 32'(pop[i]), 0);
         chk($sformatf("rst_done u%0d", i), 32'(done[i]), 0);
      end
      clear_n = 1'b1;
      en[0] = 1'b1;
      repeat (10) @(negedge clk);
      chk("empty_idle_tx", 32'(tx[0]), 1);
      chk("empty_idle_busy", 32'(busy[0]), 0);
      chk("empty_no_pop", npop[0], 0);

      push(0, 32'hABCD_EF55);
      frame(0, 8'h55, 0, 1, -1, gap);
      chk("pop_to_start", gap, PL + 2);
      chk("single_pop", npop[0], 1);

      en[1] = 1'b1;
      push(1, 32'h1234_5607);
      frame(1, 8'h07, 2, 2, -1, gap);
      chk("even_pops", npop[1], 1);
      en[2] = 1'b1;
      push(2, 32'h0000_FF07);
      frame(2, 8'h07, 1, 1, -1, gap);
      chk("odd_pops", npop[2], 1);

      push(0, 32'h1111_11A1);
      push(0, 32'h2222_223C);
      push(0, 32'h3333_33FF);
      frame(0, 8'hA1, 0, 1, -1, gap);
      frame(0, 8'h3C, 0, 1, -1, gap);
      chk("gap_2", gap, PL + 2);
      frame(0, 8'hFF, 0, 1, -1, gap);
      chk("gap_3", gap, PL + 2);
      repeat (20) @(negedge clk);
      chk("no_fourth_pop", npop[0], 4);
      chk("drained_busy", 32'(busy[0]), 0);
      chk("drained_tx", 32'(tx[0]), 1);

      push(0, 32'h0000_0081);
      push(0, 32'h0000_0042);
      frame(0, 8'h81, 0, 1, 12, gap);
      repeat (20) @(negedge clk);
      chk("disabled_no_pop", npop[0], 5);
      chk("disabled_busy", 32'(busy[0]), 0);
      en[0] = 1'b1;
      frame(0, 8'h42, 0, 1, -1, gap);
      chk("reenable_latency", gap, PL + 2);
      chk("reenable_pops", npop[0], 6);

      push(0, 32'h0000_003C);
      gap = 0;
      while (tx[0] !== 1'b0 && gap < 50) begin
         @(negedge clk);
         gap++;
      end
      chk("reset_start_seen", 32'(tx[0]), 0);
      @(posedge clk);
      #2 clear_n = 1'b0;
      #1;
      chk("reset_async_tx", 32'(tx[0]), 1);
      chk("reset_async_busy", 32'(busy[0]), 0);
      push(0, 32'h0000_0096);
      @(negedge clk);
      chk("reset_held_tx", 32'(tx[0]), 1);
      chk("reset_held_done", 32'(done[0]), 0);
      chk("reset_no_pop", npop[0], 7);
      clear_n = 1'b1;
      frame(0, 8'h96, 0, 1, -1, gap);
      chk("post_reset_latency", gap, PL + 2);
      chk("post_reset_pops", npop[0], 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rs232_fifo_transmitter.md
# rs232_fifo_transmitter

Drains bytes from the pop side of the project's `fifo` block and serialises them onto an RS232 TX line. Each frame is a start bit, DATA_BITS data bits LSB-first, an optional parity bit and 1 or 2 stop bits. It is the consumer end of the FIFO's push/pop interface, paired with the FIFO that the host side fills via `push`. It pops one word at a time, and only when the FIFO reports data and the line is idle.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clk cycles per serial bit; legal range 4..65535 (50 MHz / 115200).
- DATA_BITS, 8: serial data bits per frame; legal range 5..8.
- FIFO_WIDTH, 32: width of `fifo_data`; must be ≥ DATA_BITS.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- POP_LATENCY, 2: cycles from the `fifo_pop` pulse to valid `fifo_data`; legal range 1..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new frame starts; a frame in progress completes.
- fifo_empty  in  1  FIFO has no data; connect to `popped_last`.
- fifo_pop  out  1  single-cycle pop request to the FIFO `pop` input.
- fifo_data  in  FIFO_WIDTH  FIFO `out_data`; only bits [DATA_BITS-1:0] are transmitted.
- tx  out  1  serial line; idle high.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- Reset values (async, clear_n low): tx=1, fifo_pop=0, busy=0, frame_done=0, state=IDLE, all counters and the shift register 0.
- States and transitions:
  - IDLE: if enable=1 and fifo_empty=0, go to POP_REQ.
  - POP_REQ: fifo_pop=1 for exactly this cycle, then go to POP_WAIT.
  - POP_WAIT: count POP_LATENCY cycles. On the final cycle, latch fifo_data[DATA_BITS-1:0] into the shift register, compute parity, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - PARITY: tx = XOR of the data bits for even parity, inverted for odd; held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. frame_done pulses on the last cycle, then go to IDLE.
- Only one pop is in flight at a time. fifo_pop is never asserted outside POP_REQ.
- fifo_empty is sampled only in IDLE. The FIFO refreshes `popped_last` about 4 cycles after a pop. CLKS_PER_BIT ≥ 4 guarantees the flag is current by the time IDLE is re-entered.
- enable dropping in POP_WAIT or any later state: the frame completes normally.
- The bit counter is $clog2(DATA_BITS+1) bits wide. The baud counter is 16 bits, counts 0..CLKS_PER_BIT-1 and wraps.
- fifo_data bits above DATA_BITS-1 are ignored.

## Timing
- tx is registered, with no combinational path from any input.
- Pop-to-start-bit latency: POP_REQ at cycle N, tx falls at cycle N+1+POP_LATENCY.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles after tx falls.
- Back-to-back: after frame_done, IDLE (1 cycle) → POP_REQ (1) → POP_WAIT (POP_LATENCY) → next start bit. The inter-frame idle gap is POP_LATENCY+2 cycles of tx=1.
- Reset mid-frame: tx returns high asynchronously. No frame_done is issued and no further pop occurs until the block re-enters IDLE with enable high.

## Structure
- Shared package `rs232_pkg` holds:
  - the state enum (IDLE, POP_REQ, POP_WAIT, START, DATA, PARITY, STOP);
  - parity localparams PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2;
  - the default CLKS_PER_BIT.
  The same package is reused by the future receiver.
- One sub-module, `rs232_bit_timer`:
  - ports: clk, clear_n, run, CLKS_PER_BIT parameter, bit_tick output;
  - bit_tick pulses on the last cycle of each bit period;
  - the counter restarts whenever run rises.

## Test plan
- Reset with CLKS_PER_BIT=4, PARITY=0: tx=1, busy=0, fifo_pop=0 while clear_n=0 and for as long as fifo_empty=1.
- FIFO preloaded with 0x55, enable=1 → one fifo_pop pulse. After POP_LATENCY+1 cycles, tx sequence is 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. frame_done fires once, then busy=0.
- PARITY=2 with 0x07 → parity bit 1. PARITY=1 with 0x07 → parity bit 0. STOP_BITS=2 → 8 high cycles before frame_done.
- FIFO preloaded with 0xA1,0x3C,0xFF → three frames in that order. Inter-frame idle gap is exactly POP_LATENCY+2 cycles. After the third frame, fifo_empty=1 and no fourth pop occurs.
- enable lowered mid-DATA of 0x81 → frame completes with correct bits. No further fifo_pop occurs while enable=0.
- clear_n pulsed low mid-START → tx=1 in the same cycle (async). After release with enable=1 and data available, a fresh full frame is sent.
